xalu_ise_issue: RTL and testbench
=================================

# xalu_ise_issue

Core-side issue and writeback controller for the custom-instruction ALU. It accepts one RV32 instruction at a time from decode and recognises the four custom opcodes. It drives the ALU's fn/imm/operand/valid request, then waits for the output-valid response and returns the result to the register-file write port. Missing responses and non-custom opcodes become an illegal-instruction trap.

## Interface
- `TIMEOUT`, 4: cycles in ISSUE without `ise_oval` before trapping; legal range 1..15.
- `ise_clk`  in  1  clock; all state updates on the rising edge.
- `ise_rst`  in  1  asynchronous reset, active-high.
- `instr_valid`  in  1  decode offers an instruction.
- `instr_ready`  out  1  block can accept; high only in IDLE.
- `instr`  in  32  raw instruction word.
- `rs1_data`, `rs2_data`  in  32 each  operand values, sampled with `instr`.
- `ise_fn`  out  6  `{1'b0, instr[14:12], instr[6:5]}`.
- `ise_imm`  out  7  `instr[31:25]` (funct7).
- `ise_in1`, `ise_in2`  out  32 each  latched operands.
- `ise_val`  out  1  request valid; high for every ISSUE cycle.
- `ise_oval`  in  1  ALU response valid; may be combinational from `ise_val`.
- `ise_out`  in  32  ALU result.
- `wb_valid`  out  1  result ready for the register file.
- `wb_ready`  in  1  register file accepts.
- `wb_rd`  out  5  destination register, `instr[11:7]`.
- `wb_data`  out  32  captured `ise_out`.
- `trap`  out  1  one-cycle illegal-instruction pulse.
- `cnt_issue`, `cnt_trap`  out  32 each  performance counters (see Configuration).

## Operation
- **Custom opcodes:** `instr[6:0]` ∈ {0001011, 0101011, 1011011, 1111011}; any other opcode is non-custom.
- **States:** IDLE, ISSUE, WB, TRAP.
- **IDLE:** `instr_ready=1`. On `instr_valid & instr_ready`, latch the instruction fields, `rs1_data` and `rs2_data`.
  - Custom opcode → ISSUE, watchdog counter cleared to 0.
  - Otherwise → TRAP.
- **ISSUE:** `ise_val=1`; fn/imm/in1/in2 are driven from the latches and held stable.
  - `ise_oval=1` → capture `ise_out` into `wb_data`. Go to WB if `rd≠0`, otherwise to IDLE (result discarded).
  - `ise_oval=0` → counter increments. When the counter reaches `TIMEOUT-1` with `ise_oval` still low, go to TRAP.
  - `ise_oval` arriving in the same cycle as the limit wins; no trap.
- **WB:** `wb_valid=1`; `wb_rd` and `wb_data` are held stable until `wb_valid & wb_ready`, then → IDLE.
- **TRAP:** `trap=1` for exactly one cycle, then → IDLE; no writeback.
- `ise_oval` seen outside ISSUE is ignored.
- Request outputs (`ise_fn`, `ise_imm`, `ise_in1`, `ise_in2`) read 0 whenever `ise_val=0`.

## Timing
- **Reset values:** state IDLE; `ise_val`, `wb_valid`, `trap`, `ise_fn`, `ise_imm`, `ise_in1`, `ise_in2`, `wb_rd`, `wb_data`, counters all 0. `instr_ready` is 1, since it is decoded from IDLE.
- **Latency:** accept in cycle 0 → `ise_val` in cycle 1 → `wb_valid` in cycle 2 when `ise_oval` is immediate. Each extra ALU wait cycle adds one.
- **Throughput:** one instruction per 3 cycles at best; `instr_ready` drops the cycle after acceptance.
- **Trap latency:** non-custom opcode → `trap` one cycle after accept. Timeout → `trap` one cycle after the last ISSUE cycle, giving exactly `TIMEOUT` cycles of `ise_val`.
- **Reset mid-operation:** `ise_val`, `wb_valid` and `trap` drop asynchronously with `ise_rst`; any in-flight instruction is lost and produces no writeback or trap.
- **WB-to-IDLE handshake:** `wb_ready` high in the same cycle as `wb_valid` completes the handshake. The next instruction can be accepted the following cycle.

## Configuration
- **`XALU_ISE_ISSUE_CNT_EN` defined:**
  - `cnt_issue` increments on each ISSUE exit caused by `ise_oval`.
  - `cnt_trap` increments on each TRAP entry.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- **`XALU_ISE_ISSUE_CNT_EN` undefined:** both ports are tied to 0 and no counter flops exist.

## Structure
- Package `xalu_ise_pkg` holds:
  - the custom opcode constants;
  - the `CUSTOM_0..3` 2-bit encodings;
  - the state enum;
  - the width constants (fn 6, imm 7, data 32).
- One combinational sub-module, `xalu_ise_dec`: instruction → {is_custom, fn, imm, rd}. The FSM, latches, watchdog and counters live in the top.

## Test plan
- **Custom-1 issue:** `instr` = funct7 0x00, rd=5, opcode 0101011; rs1=0x12345678; ALU returns 0xCAFEBABE with immediate `ise_oval`. Expect `ise_fn=6'b000001`, `ise_imm=0`, `ise_in1=0x12345678` in cycle 1, then `wb_valid` cycle 2 with `wb_rd=5`, `wb_data=0xCAFEBABE`.
- **Non-custom opcode:** opcode 0110011. Expect `trap` high exactly one cycle (cycle 1), `ise_val` never high, `instr_ready` high again in cycle 2.
- **Timeout:** `TIMEOUT=4`, `ise_oval` held 0. Expect `ise_val` high for cycles 1–4, `trap` in cycle 5, no `wb_valid`, `cnt_trap=1` when the macro is defined.
- **Writeback backpressure:** `wb_ready` low for 3 cycles. Expect `wb_valid`, `wb_rd` and `wb_data` stable throughout, `instr_ready=0` until the handshake, and IDLE the cycle after.
- **rd=x0:** custom-0 instruction with rd=0 and an immediate response. Expect no `wb_valid`, `instr_ready=1` in cycle 2, `cnt_issue` incremented.
- **Reset during ISSUE:** assert `ise_rst` mid-cycle while `ise_val=1` and `ise_oval=0`. Expect `ise_val` to drop immediately, all outputs at reset values, no `trap` after release.

Source files
------------

// File: rtl/xalu_ise_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xalu_ise_pkg
// Description : Shared constants, encodings and state type for the
//               custom-instruction ALU issue/writeback controller.
// Revision    : 1.0 - initial release
// ============================================================================
package xalu_ise_pkg;

    // Field widths of the ALU request/response
    localparam int FN_W   = 6;
    localparam int IMM_W  = 7;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;

    // RV32 custom opcode space
    localparam logic [6:0] OPC_CUSTOM_0 = 7'b0001011;
    localparam logic [6:0] OPC_CUSTOM_1 = 7'b0101011;
    localparam logic [6:0] OPC_CUSTOM_2 = 7'b1011011;
    localparam logic [6:0] OPC_CUSTOM_3 = 7'b1111011;

    // Two-bit custom slot encodings, identical to instr[6:5] of each opcode
    localparam logic [1:0] CUSTOM_0 = 2'b00;
    localparam logic [1:0] CUSTOM_1 = 2'b01;
    localparam logic [1:0] CUSTOM_2 = 2'b10;
    localparam logic [1:0] CUSTOM_3 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2,
        ST_TRAP  = 2'd3
    } state_e;

    function automatic logic is_custom_opc(input logic [6:0] opc);
        return (opc == OPC_CUSTOM_0) || (opc == OPC_CUSTOM_1) ||
               (opc == OPC_CUSTOM_2) || (opc == OPC_CUSTOM_3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xalu_ise_dec.sv
`default_nettype none
// ============================================================================
// Module      : xalu_ise_dec
// Description : Combinational decode of a raw RV32 word into the custom-ALU
//               request fields: custom flag, fn, funct7 immediate and rd.
// Revision    : 1.0 - initial release
// ============================================================================
module xalu_ise_dec
    import xalu_ise_pkg::*;
(
    input  logic [31:0]      instr,
    output logic             is_custom,
    output logic [FN_W-1:0]  fn,
    output logic [IMM_W-1:0] imm,
    output logic [RD_W-1:0]  rd
);

    // Source-register fields are not used; operand values arrive separately
    logic unused_fields;
    assign unused_fields = ^instr[24:15];

    // Field extraction; fn packs funct3 with the custom slot number
    always_comb begin
        is_custom = is_custom_opc(instr[6:0]);
        fn        = {1'b0, instr[14:12], instr[6:5]};
        imm       = instr[31:25];
        rd        = instr[11:7];
    end

endmodule
`default_nettype wire

// File: rtl/xalu_ise_issue.sv
`default_nettype none
// ============================================================================
// Module      : xalu_ise_issue
// Description : Issue/writeback controller for the custom-instruction ALU.
//               Accepts one instruction, issues it to the ALU with a
//               watchdog, writes the result back or raises a one-cycle trap.
//               Optional macro XALU_ISE_ISSUE_CNT_EN enables the issue/trap
//               performance counters; otherwise the counter ports read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module xalu_ise_issue
    import xalu_ise_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4
)(
    input  logic              ise_clk,
    input  logic              ise_rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output logic [FN_W-1:0]   ise_fn,
    output logic [IMM_W-1:0]  ise_imm,
    output logic [DATA_W-1:0] ise_in1,
    output logic [DATA_W-1:0] ise_in2,
    output logic              ise_val,
    input  logic              ise_oval,
    input  logic [DATA_W-1:0] ise_out,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              trap,
    output logic [DATA_W-1:0] cnt_issue,
    output logic [DATA_W-1:0] cnt_trap
);

    localparam int WD_W = 4;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [FN_W-1:0]   fn_q, fn_d;
    logic [IMM_W-1:0]  imm_q, imm_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0] in1_q, in1_d;
    logic [DATA_W-1:0] in2_q, in2_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              ise_val_q, wb_valid_q, trap_q;

    logic              dec_custom;
    logic [FN_W-1:0]   dec_fn;
    logic [IMM_W-1:0]  dec_imm;
    logic [RD_W-1:0]   dec_rd;

    xalu_ise_dec u_dec (
        .instr     (instr),
        .is_custom (dec_custom),
        .fn        (dec_fn),
        .imm       (dec_imm),
        .rd        (dec_rd)
    );

    // Next-state, operand latching, watchdog and result capture
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        fn_d      = fn_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        wb_data_d = wb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    fn_d    = dec_fn;
                    imm_d   = dec_imm;
                    rd_d    = dec_rd;
                    in1_d   = rs1_data;
                    in2_d   = rs2_data;
                    wd_d    = '0;
                    state_d = dec_custom ? ST_ISSUE : ST_TRAP;
                end
            end
            ST_ISSUE: begin
                // A response in the limit cycle still wins over the watchdog
                if (ise_oval) begin
                    wb_data_d = ise_out;
                    state_d   = (rd_q != '0) ? ST_WB : ST_IDLE;
                end else if (wd_q == WD_LIMIT) begin
                    state_d = ST_TRAP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs registered from next state
    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            state_q    <= ST_IDLE;
            wd_q       <= '0;
            fn_q       <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            wb_data_q  <= '0;
            ise_val_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            fn_q       <= fn_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            wb_data_q  <= wb_data_d;
            ise_val_q  <= (state_d == ST_ISSUE);
            wb_valid_q <= (state_d == ST_WB);
            trap_q     <= (state_d == ST_TRAP);
        end
    end

    // Request fields are only visible while the request is valid
    always_comb begin
        instr_ready = (state_q == ST_IDLE);
        ise_val     = ise_val_q;
        ise_fn      = ise_val_q ? fn_q  : '0;
        ise_imm     = ise_val_q ? imm_q : '0;
        ise_in1     = ise_val_q ? in1_q : '0;
        ise_in2     = ise_val_q ? in2_q : '0;
        wb_valid    = wb_valid_q;
        wb_rd       = rd_q;
        wb_data     = wb_data_q;
        trap        = trap_q;
    end

`ifdef XALU_ISE_ISSUE_CNT_EN
    logic [DATA_W-1:0] cnt_issue_q, cnt_issue_d;
    logic [DATA_W-1:0] cnt_trap_q, cnt_trap_d;

    // Count ALU completions and trap entries; both wrap naturally
    always_comb begin
        cnt_issue_d = cnt_issue_q;
        cnt_trap_d  = cnt_trap_q;
        if ((state_q == ST_ISSUE) && ise_oval) begin
            cnt_issue_d = cnt_issue_q + 1'b1;
        end
        if ((state_d == ST_TRAP) && (state_q != ST_TRAP)) begin
            cnt_trap_d = cnt_trap_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            cnt_issue_q <= '0;
            cnt_trap_q  <= '0;
        end else begin
            cnt_issue_q <= cnt_issue_d;
            cnt_trap_q  <= cnt_trap_d;
        end
    end

    assign cnt_issue = cnt_issue_q;
    assign cnt_trap  = cnt_trap_q;
`else
    assign cnt_issue = '0;
    assign cnt_trap  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xalu_ise_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_xalu_ise_issue
// Description : Self-checking bench for xalu_ise_issue: directed vector
//               table plus timeout, backpressure and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xalu_ise_issue;

    logic        ise_clk = 1'b0;
    logic        ise_rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data, rs2_data;
    logic [5:0]  ise_fn;
    logic [6:0]  ise_imm;
    logic [31:0] ise_in1, ise_in2;
    logic        ise_val;
    logic        ise_oval;
    logic [31:0] ise_out;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        trap;
    logic [31:0] cnt_issue, cnt_trap;

    xalu_ise_issue #(.TIMEOUT(4)) dut (
        .ise_clk     (ise_clk),
        .ise_rst     (ise_rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .ise_fn      (ise_fn),
        .ise_imm     (ise_imm),
        .ise_in1     (ise_in1),
        .ise_in2     (ise_in2),
        .ise_val     (ise_val),
        .ise_oval    (ise_oval),
        .ise_out     (ise_out),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .trap        (trap),
        .cnt_issue   (cnt_issue),
        .cnt_trap    (cnt_trap)
    );

    always #5 ise_clk = ~ise_clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] alu;
        int          delay;
        bit          trap;
        bit          wb;
        logic [4:0]  rd;
        logic [5:0]  fn;
        logic [6:0]  imm;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;
    int   exp_issue = 0;
    int   exp_trap  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge ise_clk);
        #1;
    endtask

    task automatic chk_counters();
        logic [31:0] ei, et;
`ifdef XALU_ISE_ISSUE_CNT_EN
        ei = 32'(exp_issue);
        et = 32'(exp_trap);
`else
        ei = 32'd0;
        et = 32'd0;
`endif
        chk("cnt_issue", cnt_issue, ei);
        chk("cnt_trap", cnt_trap, et);
    endtask

    task automatic accept(input logic [31:0] iw, input logic [31:0] r1, input logic [31:0] r2);
        tick();
        instr_valid = 1'b1;
        instr       = iw;
        rs1_data    = r1;
        rs2_data    = r2;
        #1;
        chk("accept_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
        instr       = 32'd0;
        rs1_data    = 32'd0;
        rs2_data    = 32'd0;
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        accept(v.instr, v.rs1, v.rs2);
        if (v.trap) begin
            chk("ntrap_trap", {31'd0, trap}, 32'd1);
            chk("ntrap_val", {31'd0, ise_val}, 32'd0);
            exp_trap++;
            tick();
            #1;
            chk("ntrap_trap_off", {31'd0, trap}, 32'd0);
            chk("ntrap_ready", {31'd0, instr_ready}, 32'd1);
        end else begin
            for (int w = 0; w <= v.delay; w++) begin
                chk("iss_val", {31'd0, ise_val}, 32'd1);
                chk("iss_fn", {26'd0, ise_fn}, {26'd0, v.fn});
                chk("iss_imm", {25'd0, ise_imm}, {25'd0, v.imm});
                chk("iss_in1", ise_in1, v.rs1);
                chk("iss_in2", ise_in2, v.rs2);
                ise_oval = (w == v.delay);
                ise_out  = (w == v.delay) ? v.alu : 32'h5555_AAAA;
                tick();
                ise_oval = 1'b0;
                ise_out  = 32'd0;
                #1;
            end
            exp_issue++;
            chk("post_trap", {31'd0, trap}, 32'd0);
            chk("post_val", {31'd0, ise_val}, 32'd0);
            if (v.wb) begin
                chk("wb_valid", {31'd0, wb_valid}, 32'd1);
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, v.rd});
                chk("wb_data", wb_data, v.alu);
                chk("wb_busy", {31'd0, instr_ready}, 32'd0);
                tick();
                #1;
                chk("wb_done", {31'd0, wb_valid}, 32'd0);
            end else begin
                chk("x0_no_wb", {31'd0, wb_valid}, 32'd0);
            end
            chk("idle_ready", {31'd0, instr_ready}, 32'd1);
        end
        chk_counters();
    endtask

    initial begin
        //           instr         rs1           rs2           alu          dly trap wb rd     fn      imm
        vecs[0] = '{32'h0000_02AB, 32'h1234_5678, 32'h9ABC_DEF0, 32'hCAFE_BABE, 0, 0, 1, 5'd5,  6'h01, 7'h00};
        vecs[1] = '{32'h0000_00B3, 32'h1111_1111, 32'h2222_2222, 32'h0,         0, 1, 0, 5'd0,  6'h00, 7'h00};
        vecs[2] = '{32'h5400_500B, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1111_2222, 0, 0, 0, 5'd0,  6'h14, 7'h2A};
        vecs[3] = '{32'hFE00_7FDB, 32'h0F0F_0F0F, 32'hA5A5_A5A5, 32'h0000_0001, 2, 0, 1, 5'd31, 6'h1E, 7'h7F};
        vecs[4] = '{32'h0200_257B, 32'h8000_0000, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 3, 0, 1, 5'd10, 6'h0B, 7'h01};
        vecs[5] = '{32'h0000_007F, 32'h3333_3333, 32'h4444_4444, 32'h0,         0, 1, 0, 5'd0,  6'h00, 7'h00};
        vecs[6] = '{32'h0000_000F, 32'h5555_5555, 32'h6666_6666, 32'h0,         0, 1, 0, 5'd0,  6'h00, 7'h00};

        ise_rst     = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        rs1_data    = 32'd0;
        rs2_data    = 32'd0;
        ise_oval    = 1'b0;
        ise_out     = 32'd0;
        wb_ready    = 1'b1;

        // Reset state
        tick();
        #1;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_val", {31'd0, ise_val}, 32'd0);
        chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_fn", {26'd0, ise_fn}, 32'd0);
        chk("rst_imm", {25'd0, ise_imm}, 32'd0);
        chk("rst_in1", ise_in1, 32'd0);
        chk("rst_in2", ise_in2, 32'd0);
        chk("rst_wbrd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk_counters();
        tick();
        ise_rst = 1'b0;

        // Table-driven transactions
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Watchdog timeout: exactly four ISSUE cycles, then a trap
        accept(32'h0000_02AB, 32'hAAAA_0001, 32'hBBBB_0002);
        for (int c = 1; c <= 4; c++) begin
            chk("to_val", {31'd0, ise_val}, 32'd1);
            chk("to_no_trap", {31'd0, trap}, 32'd0);
            tick();
            #1;
        end
        chk("to_trap", {31'd0, trap}, 32'd1);
        chk("to_val_off", {31'd0, ise_val}, 32'd0);
        chk("to_no_wb", {31'd0, wb_valid}, 32'd0);
        exp_trap++;
        tick();
        #1;
        chk("to_trap_off", {31'd0, trap}, 32'd0);
        chk("to_ready", {31'd0, instr_ready}, 32'd1);
        chk("to_no_wb2", {31'd0, wb_valid}, 32'd0);
        chk_counters();

        // Writeback backpressure: three stalled WB cycles
        wb_ready = 1'b0;
        accept(32'h0200_257B, 32'h0000_0001, 32'h0000_0002);
        chk("bp_val", {31'd0, ise_val}, 32'd1);
        ise_oval = 1'b1;
        ise_out  = 32'h1357_9BDF;
        tick();
        ise_oval = 1'b0;
        ise_out  = 32'hFFFF_0000;
        #1;
        exp_issue++;
        for (int c = 0; c < 3; c++) begin
            chk("bp_wbv", {31'd0, wb_valid}, 32'd1);
            chk("bp_rd", {27'd0, wb_rd}, 32'd10);
            chk("bp_data", wb_data, 32'h1357_9BDF);
            chk("bp_ready", {31'd0, instr_ready}, 32'd0);
            tick();
            #1;
        end
        wb_ready = 1'b1;
        #1;
        chk("bp_hs_wbv", {31'd0, wb_valid}, 32'd1);
        chk("bp_hs_data", wb_data, 32'h1357_9BDF);
        tick();
        #1;
        chk("bp_idle_wbv", {31'd0, wb_valid}, 32'd0);
        chk("bp_idle_ready", {31'd0, instr_ready}, 32'd1);
        chk_counters();

        // Asynchronous reset in the middle of an ISSUE cycle
        accept(32'hFE00_7FDB, 32'hCCCC_CCCC, 32'hDDDD_DDDD);
        chk("mr_val_pre", {31'd0, ise_val}, 32'd1);
        #2;
        ise_rst = 1'b1;
        #1;
        exp_issue = 0;
        exp_trap  = 0;
        chk("mr_val", {31'd0, ise_val}, 32'd0);
        chk("mr_ready", {31'd0, instr_ready}, 32'd1);
        chk("mr_fn", {26'd0, ise_fn}, 32'd0);
        chk("mr_in1", ise_in1, 32'd0);
        chk("mr_wbv", {31'd0, wb_valid}, 32'd0);
        chk("mr_wbdata", wb_data, 32'd0);
        chk("mr_wbrd", {27'd0, wb_rd}, 32'd0);
        chk("mr_trap", {31'd0, trap}, 32'd0);
        chk_counters();
        tick();
        ise_rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            #1;
            chk("mr_post_trap", {31'd0, trap}, 32'd0);
            chk("mr_post_wbv", {31'd0, wb_valid}, 32'd0);
            chk("mr_post_val", {31'd0, ise_val}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
